// File: rtl/gpu_cmd_ctrl_if.sv
// rtl/gpu_cmd_ctrl_if.sv - command and glyph-buffer write bus for gpu_cmd_ctrl
//
// Purpose: bundles the command handshake and the glyph-buffer write port.
// Signals:
//   cmd_valid  host -> ctrl  command present
//   cmd_ready  ctrl -> host  controller accepts a command this cycle
//   cmd_op     host -> ctrl  00 STORE_BYTE, 01 MOVE_CURSOR, 10 DISPLAY, 11 CLEAR
//   cmd_data   host -> ctrl  glyph code, cursor delta or fill glyph
//   mem_we     ctrl -> mem   glyph-buffer write strobe
//   mem_addr   ctrl -> mem   cell index y*TEXT_W+x
//   mem_wdata  ctrl -> mem   glyph code to write
//   mem_buf    ctrl -> mem   buffer being written (back buffer)
// Modports: master = command host / memory side, slave = controller.
interface gpu_cmd_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_buf;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, mem_we, mem_addr, mem_wdata, mem_buf
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, mem_we, mem_addr, mem_wdata, mem_buf
  );
endinterface

// File: rtl/gpu_cmd_ctrl.sv
// rtl/gpu_cmd_ctrl.sv - text-mode GPU command controller with double-buffered glyph memory
//
// Purpose: accepts STORE_BYTE / MOVE_CURSOR / DISPLAY / CLEAR commands, writes
// glyphs into the back buffer, tracks the text cursor and swaps the displayed
// buffer on vertical blank.
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous active-high reset
//   bus           gpu_cmd_ctrl_if.slave (command handshake + glyph write port)
//   vblank_start  one-cycle pulse at start of vertical blank
//   active_buf    buffer currently scanned out
//   cursor_x      current column 0..TEXT_W-1
//   cursor_y      current row 0..TEXT_H-1
//   busy          high whenever the controller is not IDLE
module gpu_cmd_ctrl #(
  parameter int TEXT_W = 80,
  parameter int TEXT_H = 60
) (
  input  logic                clk,
  input  logic                rst,
  gpu_cmd_ctrl_if.slave       bus,
  input  logic                vblank_start,
  output logic                active_buf,
  output logic [6:0]          cursor_x,
  output logic [5:0]          cursor_y,
  output logic                busy
);

  localparam logic [7:0]  X_MOD      = 8'(TEXT_W);
  localparam logic [6:0]  Y_MOD      = 7'(TEXT_H);
  localparam logic [6:0]  X_LAST     = 7'(TEXT_W - 1);
  localparam logic [5:0]  Y_LAST     = 6'(TEXT_H - 1);
  localparam logic [12:0] ROW_STRIDE = 13'(TEXT_W);
  localparam logic [12:0] ADDR_LAST  = 13'(TEXT_W * TEXT_H - 1);

  localparam logic [1:0] OP_STORE   = 2'b00;
  localparam logic [1:0] OP_MOVE    = 2'b01;
  localparam logic [1:0] OP_DISPLAY = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SWAP_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_mem_we;
  logic [12:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_active_buf;
  logic [6:0]  r_cursor_x;
  logic [5:0]  r_cursor_y;
  logic [7:0]  r_fill;

  logic        w_mem_we_next;
  logic [12:0] w_mem_addr_next;
  logic [7:0]  w_mem_wdata_next;
  logic        w_active_buf_next;
  logic [6:0]  w_cursor_x_next;
  logic [5:0]  w_cursor_y_next;
  logic [7:0]  w_fill_next;

  logic        w_cmd_ready;
  logic        w_accept;
  logic [7:0]  w_x_sum;
  logic [6:0]  w_y_sum;
  logic [12:0] w_store_addr;

  // Gating with rst keeps cmd_ready low while reset is held, even though
  // the state register already reads IDLE.
  assign w_cmd_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept    = bus.cmd_valid && w_cmd_ready;

  // Sums are one bit wider than the cursor so the modulo sees the full value.
  assign w_x_sum      = {1'b0, r_cursor_x} + {1'b0, bus.cmd_data[6:0]};
  assign w_y_sum      = {1'b0, r_cursor_y} + {1'b0, bus.cmd_data[5:0]};
  assign w_store_addr = {6'd0, r_cursor_y} * ROW_STRIDE + {6'd0, r_cursor_x};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_mem_we_next     = 1'b0;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_active_buf_next = r_active_buf;
    w_cursor_x_next   = r_cursor_x;
    w_cursor_y_next   = r_cursor_y;
    w_fill_next       = r_fill;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (bus.cmd_op)
            OP_STORE: begin
              w_mem_we_next    = 1'b1;
              w_mem_addr_next  = w_store_addr;
              w_mem_wdata_next = bus.cmd_data;
              if (r_cursor_x == X_LAST) begin
                w_cursor_x_next = 7'd0;
                w_cursor_y_next = (r_cursor_y == Y_LAST) ? 6'd0 : r_cursor_y + 6'd1;
              end else begin
                w_cursor_x_next = r_cursor_x + 7'd1;
              end
            end
            OP_MOVE: begin
              // Bit 7 selects the axis; bit 6 only belongs to the x delta.
              if (bus.cmd_data[7]) begin
                w_cursor_x_next = 7'(w_x_sum % X_MOD);
              end else begin
                w_cursor_y_next = 6'(w_y_sum % Y_MOD);
              end
            end
            OP_DISPLAY: begin
              w_state_next = ST_SWAP_WAIT;
            end
            default: begin
              // CLEAR: the first fill write goes out on the next cycle.
              w_state_next     = ST_CLEAR;
              w_fill_next      = bus.cmd_data;
              w_mem_we_next    = 1'b1;
              w_mem_addr_next  = 13'd0;
              w_mem_wdata_next = bus.cmd_data;
            end
          endcase
        end
      end

      ST_CLEAR: begin
        // r_mem_addr is the cell being written this cycle and doubles as
        // the sweep counter.
        if (r_mem_addr == ADDR_LAST) begin
          w_state_next    = ST_IDLE;
          w_cursor_x_next = 7'd0;
          w_cursor_y_next = 6'd0;
        end else begin
          w_mem_we_next    = 1'b1;
          w_mem_addr_next  = r_mem_addr + 13'd1;
          w_mem_wdata_next = r_fill;
        end
      end

      ST_SWAP_WAIT: begin
        if (vblank_start) begin
          w_active_buf_next = !r_active_buf;
          w_state_next      = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 13'd0;
      r_mem_wdata  <= 8'd0;
      r_active_buf <= 1'b0;
      r_cursor_x   <= 7'd0;
      r_cursor_y   <= 6'd0;
      r_fill       <= 8'd0;
    end else begin
      r_mem_we     <= w_mem_we_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_active_buf <= w_active_buf_next;
      r_cursor_x   <= w_cursor_x_next;
      r_cursor_y   <= w_cursor_y_next;
      r_fill       <= w_fill_next;
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_buf   = !r_active_buf;

  assign active_buf = r_active_buf;
  assign cursor_x   = r_cursor_x;
  assign cursor_y   = r_cursor_y;
  assign busy       = (r_state != ST_IDLE);

endmodule
